// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: synchronises SCL/SDA, classifies START/STOP/bit edges
// and frames bytes, reporting each completed byte together with its ACK bit.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TO_W           = 16
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       SCL,
  input  logic       SDA,
  output logic       Start,
  output logic       Stop,
  output logic       ByteValid,
  output logic [7:0] ByteData,
  output logic       IsAddr,
  output logic       Ack,
  output logic       Busy,
  output logic       Timeout
);

  typedef enum logic [1:0] {IDLE, ADDR, ACK, DATA} state_t;

  state_t state, stateNext;

  logic [SYNC_STAGES-1:0] sclSync, sdaSync;
  logic prevScl, crntScl, prevSda, crntSda;
  logic sclRise, sclEdge, startDet, stopDet, toTerminal;

  logic [2:0]      bitCnt, bitCntNext;
  logic [7:0]      shiftReg, shiftNext;
  logic            fromAddr, fromAddrNext;
  logic [TO_W-1:0] toCnt;

  logic       startNext, stopNext, validNext, isAddrNext, ackNext;
  logic [7:0] dataNext;

  // Synchronisers and edge registers reset to the idle-bus level so reset
  // release never looks like an edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sclSync <= '1;
      sdaSync <= '1;
      prevScl <= 1'b1;
      crntScl <= 1'b1;
      prevSda <= 1'b1;
      crntSda <= 1'b1;
    end else begin
      sclSync <= {sclSync[SYNC_STAGES-2:0], SCL};
      sdaSync <= {sdaSync[SYNC_STAGES-2:0], SDA};
      crntScl <= sclSync[SYNC_STAGES-1];
      prevScl <= crntScl;
      crntSda <= sdaSync[SYNC_STAGES-1];
      prevSda <= crntSda;
    end
  end

  assign sclRise  = ~prevScl & crntScl;
  assign sclEdge  = prevScl ^ crntScl;
  assign startDet = prevScl & crntScl & prevSda & ~crntSda;
  assign stopDet  = prevScl & crntScl & ~prevSda & crntSda;
  assign Busy     = (state != IDLE);

  // An SCL edge in the terminal cycle suppresses the timeout.
  assign toTerminal = Busy & ~crntScl & ~sclEdge &
                      (toCnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      toCnt <= '0;
    end else if (!Busy || sclEdge || toTerminal) begin
      toCnt <= '0;
    end else if (!crntScl) begin
      toCnt <= toCnt + 1'b1;
    end
  end

  always_comb begin
    stateNext    = state;
    bitCntNext   = bitCnt;
    shiftNext    = shiftReg;
    fromAddrNext = fromAddr;
    startNext    = 1'b0;
    stopNext     = 1'b0;
    validNext    = 1'b0;
    dataNext     = ByteData;
    isAddrNext   = IsAddr;
    ackNext      = Ack;
    if (stopDet) begin
      stateNext  = IDLE;
      bitCntNext = 3'd0;
      stopNext   = 1'b1;
    end else if (startDet) begin
      stateNext  = ADDR;
      bitCntNext = 3'd0;
      startNext  = 1'b1;
    end else if (toTerminal) begin
      stateNext  = IDLE;
      bitCntNext = 3'd0;
    end else if (sclRise) begin
      case (state)
        ADDR, DATA: begin
          shiftNext = {shiftReg[6:0], crntSda};
          if (bitCnt == 3'd7) begin
            stateNext    = ACK;
            fromAddrNext = (state == ADDR);
            bitCntNext   = 3'd0;
          end else begin
            bitCntNext = bitCnt + 3'd1;
          end
        end
        ACK: begin
          ackNext    = ~crntSda;
          dataNext   = shiftReg;
          isAddrNext = fromAddr;
          validNext  = 1'b1;
          stateNext  = DATA;
          bitCntNext = 3'd0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      bitCnt    <= 3'd0;
      shiftReg  <= 8'd0;
      fromAddr  <= 1'b0;
      Start     <= 1'b0;
      Stop      <= 1'b0;
      ByteValid <= 1'b0;
      ByteData  <= 8'd0;
      IsAddr    <= 1'b0;
      Ack       <= 1'b0;
      Timeout   <= 1'b0;
    end else begin
      state     <= stateNext;
      bitCnt    <= bitCntNext;
      shiftReg  <= shiftNext;
      fromAddr  <= fromAddrNext;
      Start     <= startNext;
      Stop      <= stopNext;
      ByteValid <= validNext;
      ByteData  <= dataNext;
      IsAddr    <= isAddrNext;
      Ack       <= ackNext;
      Timeout   <= toTerminal;
    end
  end

endmodule
